// File: rtl/fifo_bank_arbiter.sv
// Round-robin scheduler sharing NB bank FIFOs between two req/ack masters; one operation per two cycles.
// Optional grant/error statistics counters are built when ARB_STATS_EN is defined.
module fifo_bank_arbiter #(
    parameter int DW = 8,
    parameter int NB = 4,
    parameter int BW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [BW-1:0]    m0_id,
    input  logic [DW-1:0]    m0_wdata,
    output logic             m0_ack,
    output logic             m0_err,
    output logic             m0_rvalid,
    output logic [DW-1:0]    m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [BW-1:0]    m1_id,
    input  logic [DW-1:0]    m1_wdata,
    output logic             m1_ack,
    output logic             m1_err,
    output logic             m1_rvalid,
    output logic [DW-1:0]    m1_rdata,
    output logic [NB-1:0]    bank_wr_en,
    output logic [NB-1:0]    bank_rd_en,
    output logic [DW-1:0]    bank_wdata,
    input  logic [NB*DW-1:0] bank_rdata,
    input  logic [NB-1:0]    bank_full,
    input  logic [NB-1:0]    bank_empty,
`ifdef ARB_STATS_EN
    output logic [15:0]      stat_gnt0,
    output logic [15:0]      stat_gnt1,
    output logic [15:0]      stat_err,
`endif
    output logic             dbg_state
);

    // Handshake: a master raises req with stable fields and keeps them until its
    // one-cycle ack; err/rvalid/rdata are valid in the ack cycle.
    localparam logic IDLE  = 1'b0;
    localparam logic ISSUE = 1'b1;

    logic          state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [BW-1:0] wptr_q, wptr_d;
    logic          m0_ack_q, m0_ack_d, m0_err_q, m0_err_d, m0_rvalid_q, m0_rvalid_d;
    logic          m1_ack_q, m1_ack_d, m1_err_q, m1_err_d, m1_rvalid_q, m1_rvalid_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic [NB-1:0] wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          gnt_valid, gnt_m1;
    logic          sel_we;
    logic [BW-1:0] sel_id;
    logic [DW-1:0] sel_wdata, rd_slice;
    logic          found;
    logic [BW-1:0] tgt, idx;
    logic          op_err, op_rvalid;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_m1    = 1'b0;
        if (state_q == IDLE) begin
            if (m0_req && m1_req) begin
                gnt_valid = 1'b1;
                gnt_m1    = ~last_grant_q;
            end else if (m0_req) begin
                gnt_valid = 1'b1;
            end else if (m1_req) begin
                gnt_valid = 1'b1;
                gnt_m1    = 1'b1;
            end
        end
    end

    assign sel_we    = gnt_m1 ? m1_we    : m0_we;
    assign sel_id    = gnt_m1 ? m1_id    : m0_id;
    assign sel_wdata = gnt_m1 ? m1_wdata : m0_wdata;
    assign rd_slice  = bank_rdata[int'(sel_id)*DW +: DW];

    // Rotating write target: first non-full bank starting at wptr.
    always_comb begin
        found = 1'b0;
        tgt   = '0;
        idx   = '0;
        for (int i = 0; i < NB; i++) begin
            idx = wptr_q + i[BW-1:0];
            if (!found && !bank_full[idx]) begin
                found = 1'b1;
                tgt   = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wptr_d       = wptr_q;
        wr_en_d      = '0;
        rd_en_d      = '0;
        wdata_d      = wdata_q;
        op_err       = 1'b0;
        op_rvalid    = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;

        if (state_q == ISSUE) begin
            state_d = IDLE;
        end else if (gnt_valid) begin
            state_d      = ISSUE;
            last_grant_d = gnt_m1;
            if (sel_we) begin
                if (found) begin
                    wr_en_d = {{(NB-1){1'b0}}, 1'b1} << tgt;
                    wdata_d = sel_wdata;
                    wptr_d  = tgt + {{(BW-1){1'b0}}, 1'b1};
                end else begin
                    op_err = 1'b1;
                end
            end else begin
                if (!bank_empty[sel_id]) begin
                    rd_en_d   = {{(NB-1){1'b0}}, 1'b1} << sel_id;
                    op_rvalid = 1'b1;
                    if (gnt_m1) m1_rdata_d = rd_slice;
                    else        m0_rdata_d = rd_slice;
                end else begin
                    op_err = 1'b1;
                end
            end
        end

        m0_ack_d    = gnt_valid & ~gnt_m1;
        m0_err_d    = m0_ack_d & op_err;
        m0_rvalid_d = m0_ack_d & op_rvalid;
        m1_ack_d    = gnt_valid & gnt_m1;
        m1_err_d    = m1_ack_d & op_err;
        m1_rvalid_d = m1_ack_d & op_rvalid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wptr_q       <= '0;
            m0_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m0_rvalid_q  <= 1'b0;
            m0_rdata_q   <= '0;
            m1_ack_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m1_rvalid_q  <= 1'b0;
            m1_rdata_q   <= '0;
            wr_en_q      <= '0;
            rd_en_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wptr_q       <= wptr_d;
            m0_ack_q     <= m0_ack_d;
            m0_err_q     <= m0_err_d;
            m0_rvalid_q  <= m0_rvalid_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_ack_q     <= m1_ack_d;
            m1_err_q     <= m1_err_d;
            m1_rvalid_q  <= m1_rvalid_d;
            m1_rdata_q   <= m1_rdata_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            wdata_q      <= wdata_d;
        end
    end

    assign m0_ack     = m0_ack_q;
    assign m0_err     = m0_err_q;
    assign m0_rvalid  = m0_rvalid_q;
    assign m0_rdata   = m0_rdata_q;
    assign m1_ack     = m1_ack_q;
    assign m1_err     = m1_err_q;
    assign m1_rvalid  = m1_rvalid_q;
    assign m1_rdata   = m1_rdata_q;
    assign bank_wr_en = wr_en_q;
    assign bank_rd_en = rd_en_q;
    assign bank_wdata = wdata_q;
    assign dbg_state  = state_q;

`ifdef ARB_STATS_EN
    logic [15:0] gnt0_q, gnt0_d, gnt1_q, gnt1_d, err_q, err_d;

    // Saturating counters; a grant and its error outcome are counted at the grant edge.
    always_comb begin
        gnt0_d = gnt0_q;
        gnt1_d = gnt1_q;
        err_d  = err_q;
        if (gnt_valid && !gnt_m1 && gnt0_q != 16'hFFFF) gnt0_d = gnt0_q + 16'd1;
        if (gnt_valid && gnt_m1 && gnt1_q != 16'hFFFF)  gnt1_d = gnt1_q + 16'd1;
        if (gnt_valid && op_err && err_q != 16'hFFFF)   err_d  = err_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt0_q <= '0;
            gnt1_q <= '0;
            err_q  <= '0;
        end else begin
            gnt0_q <= gnt0_d;
            gnt1_q <= gnt1_d;
            err_q  <= err_d;
        end
    end

    assign stat_gnt0 = gnt0_q;
    assign stat_gnt1 = gnt1_q;
    assign stat_err  = err_q;
`endif

endmodule

// File: tb/tb_fifo_bank_arbiter.sv
// Directed bench for fifo_bank_arbiter: reset, rotating writes, round-robin, reads, full banks, mid-op reset.
module tb_fifo_bank_arbiter;

    localparam int DW = 8;
    localparam int NB = 4;
    localparam int BW = 2;

    logic             clk;
    logic             rst;
    logic             m0_req, m0_we, m1_req, m1_we;
    logic [BW-1:0]    m0_id, m1_id;
    logic [DW-1:0]    m0_wdata, m1_wdata;
    logic             m0_ack, m0_err, m0_rvalid, m1_ack, m1_err, m1_rvalid;
    logic [DW-1:0]    m0_rdata, m1_rdata;
    logic [NB-1:0]    bank_wr_en, bank_rd_en;
    logic [DW-1:0]    bank_wdata;
    logic [NB*DW-1:0] bank_rdata;
    logic [NB-1:0]    bank_full, bank_empty;
    logic             dbg_state;

    int checks;
    int failures;

    logic [38:0] all_outs;
    assign all_outs = {m0_ack, m0_err, m0_rvalid, m0_rdata, m1_ack, m1_err, m1_rvalid,
                       m1_rdata, bank_wr_en, bank_rd_en, bank_wdata, dbg_state};

    fifo_bank_arbiter #(.DW(DW), .NB(NB), .BW(BW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_id(m0_id), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_id(m1_id), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .bank_wr_en(bank_wr_en), .bank_rd_en(bank_rd_en), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata), .bank_full(bank_full), .bank_empty(bank_empty),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] wr_vals [5];
    logic [NB-1:0] wr_strb [5];

    initial begin
        checks   = 0;
        failures = 0;
        wr_vals  = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
        wr_strb  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset held with random inputs.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m0_req = 1'($urandom_range(0, 1));  m0_we = 1'($urandom_range(0, 1));
            m1_req = 1'($urandom_range(0, 1));  m1_we = 1'($urandom_range(0, 1));
            m0_id = 2'($urandom_range(0, 3));    m1_id = 2'($urandom_range(0, 3));
            m0_wdata = 8'($urandom_range(0, 255)); m1_wdata = 8'($urandom_range(0, 255));
            bank_rdata = 32'($urandom);
            bank_full  = 4'($urandom_range(0, 15));
            bank_empty = 4'($urandom_range(0, 15));
            tick();
            chk("reset_outs", 64'(all_outs), 64'd0);
        end

        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_id = '0; m1_id = '0; m0_wdata = '0; m1_wdata = '0;
        bank_rdata = '0; bank_full = '0; bank_empty = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_outs", 64'(all_outs), 64'd0);
        end

        // M0 writes rotate through the banks, one every two cycles.
        m0_we = 1'b1;
        for (int k = 0; k < 5; k++) begin
            m0_wdata = wr_vals[k];
            m0_req   = 1'b1;
            tick();
            chk("wr_ack",    64'(m0_ack),     64'd1);
            chk("wr_err",    64'(m0_err),     64'd0);
            chk("wr_m1_ack", 64'(m1_ack),     64'd0);
            chk("wr_strobe", 64'(bank_wr_en), 64'(wr_strb[k]));
            chk("wr_data",   64'(bank_wdata), 64'(wr_vals[k]));
            chk("wr_rd_en",  64'(bank_rd_en), 64'd0);
            tick();
            chk("wr_gap_ack",    64'(m0_ack),     64'd0);
            chk("wr_gap_strobe", 64'(bank_wr_en), 64'd0);
        end
        m0_req = 1'b0;

        // Both masters requesting from reset release: M0 first, then alternate.
        rst = 1'b0;
        #1;
        chk("rst2_outs", 64'(all_outs), 64'd0);
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
        m0_wdata = 8'h0A; m1_wdata = 8'h1B;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_m0_ack", 64'(m0_ack), 64'(k % 2 == 0));
            chk("rr_m1_ack", 64'(m1_ack), 64'(k % 2 == 1));
            chk("rr_strobe", 64'(bank_wr_en), 64'(4'b0001 << k));
            chk("rr_wdata",  64'(bank_wdata), (k % 2 == 0) ? 64'h0A : 64'h1B);
            tick();
            chk("rr_gap", 64'({m0_ack, m1_ack}), 64'd0);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // M1 read of an empty bank, then of a populated one.
        m1_we = 1'b0; m1_id = 2'd2; bank_empty = 4'b0100; m1_req = 1'b1;
        tick();
        chk("rd_empty_ack",    64'(m1_ack),     64'd1);
        chk("rd_empty_err",    64'(m1_err),     64'd1);
        chk("rd_empty_rvalid", 64'(m1_rvalid),  64'd0);
        chk("rd_empty_rd_en",  64'(bank_rd_en), 64'd0);
        chk("rd_empty_rdata",  64'(m1_rdata),   64'd0);
        bank_empty = 4'b0000;
        bank_rdata = {8'hD3, 8'h5C, 8'hB2, 8'hA1};
        tick();
        chk("rd_gap_ack", 64'(m1_ack), 64'd0);
        tick();
        chk("rd_ack",    64'(m1_ack),     64'd1);
        chk("rd_err",    64'(m1_err),     64'd0);
        chk("rd_rvalid", 64'(m1_rvalid),  64'd1);
        chk("rd_rdata",  64'(m1_rdata),   64'h5C);
        chk("rd_rd_en",  64'(bank_rd_en), 64'b0100);
        chk("rd_m0_ack", 64'(m0_ack),     64'd0);
        m1_req = 1'b0;
        bank_rdata = {8'h00, 8'h77, 8'h00, 8'h00};
        tick();
        chk("rd_hold_rdata", 64'(m1_rdata),   64'h5C);
        chk("rd_hold_rd_en", 64'(bank_rd_en), 64'd0);
        chk("rd_hold_rvalid", 64'(m1_rvalid), 64'd0);
        tick();

        // Full-bank skipping with wptr at 0, then all banks full.
        bank_full = 4'b1011; m0_we = 1'b1; m0_wdata = 8'h7E; m0_req = 1'b1;
        tick();
        chk("full_skip_strobe", 64'(bank_wr_en), 64'b0100);
        chk("full_skip_data",   64'(bank_wdata), 64'h7E);
        m0_req = 1'b0;
        tick();
        bank_full = 4'b0000; m0_wdata = 8'h99; m0_req = 1'b1;
        tick();
        chk("after_skip_strobe", 64'(bank_wr_en), 64'b1000);
        m0_req = 1'b0;
        tick();
        bank_full = 4'b1111; m0_wdata = 8'h42; m0_req = 1'b1;
        tick();
        chk("all_full_ack",    64'(m0_ack),     64'd1);
        chk("all_full_err",    64'(m0_err),     64'd1);
        chk("all_full_strobe", 64'(bank_wr_en), 64'd0);
        m0_req = 1'b0;
        tick();
        bank_full = 4'b0000; m0_wdata = 8'h43; m0_req = 1'b1;
        tick();
        chk("wptr_kept_strobe", 64'(bank_wr_en), 64'b0001);
        m0_req = 1'b0;
        tick();

        // Reset asserted during ISSUE of a write to bank 1.
        m0_wdata = 8'h55; m0_req = 1'b1;
        tick();
        chk("pre_rst_strobe", 64'(bank_wr_en), 64'b0010);
        m1_req = 1'b1; m1_we = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_strobe", 64'(bank_wr_en), 64'd0);
        chk("mid_rst_ack",    64'(m0_ack),     64'd0);
        chk("mid_rst_state",  64'(dbg_state),  64'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_m0_ack", 64'(m0_ack),     64'd1);
        chk("post_rst_m1_ack", 64'(m1_ack),     64'd0);
        chk("post_rst_strobe", 64'(bank_wr_en), 64'b0001);
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();
        chk("final_m1_ack", 64'(m1_ack), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_bank_arbiter.md
Name: fifo_bank_arbiter

Overview:
- Scheduler that shares a set of bank FIFOs (8-bit data, 32-entry, full/empty flags, head-of-queue data always visible) between two requesters, M0 and M1.
- Each requester posts read or write requests with a req/ack handshake.
- The arbiter grants at most one operation per two cycles, using round-robin between M0 and M1.
- It drives the bank write/read strobes, picks the target bank for writes with a rotating pointer, and returns read data and error status.

Parameters:
DW, 8, data width of requesters and banks
NB, 4, number of banks (power of two, 2..8)
BW, 2, bank index width, equal to log2(NB)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
m0_req  in  1  M0 request; held with fields stable until m0_ack
m0_we  in  1  1 = write, 0 = read
m0_id  in  BW  read bank index (ignored for writes)
m0_wdata  in  DW  write data
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  valid with m0_ack: op rejected (read of empty bank, or all banks full on write)
m0_rvalid  out  1  pulses with m0_ack on a successful read
m0_rdata  out  DW  read data; holds its value between reads
m1_req, m1_we, m1_id, m1_wdata, m1_ack, m1_err, m1_rvalid, m1_rdata: same as M0
bank_wr_en  out  NB  one-hot write strobe
bank_rd_en  out  NB  one-hot pop strobe
bank_wdata  out  DW  shared write data bus
bank_rdata  in  NB*DW  head data; bank b occupies bits [b*DW +: DW]
bank_full  in  NB  per-bank full flag
bank_empty  in  NB  per-bank empty flag

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, last_grant=1 (M1, so M0 wins first), wptr=0.
- FSM has two states: IDLE and ISSUE. All outputs are registered.
- IDLE: sample m0_req and m1_req at the rising edge.
  - Only one requesting: grant that master.
  - Both requesting: grant the master opposite last_grant.
  - On a grant: update last_grant and go to ISSUE.
  - No request: stay in IDLE; no state changes.
- ISSUE (exactly one cycle): drive the outcome of the grant, then return to IDLE.
  - No new grant is made in ISSUE.
  - This masks the still-high req of the acked master and lets bank flags settle after the strobe.
  - Maximum throughput is 1 operation per 2 cycles.
- Latency: req sampled at edge E gives ack high during cycle E..E+1.
- Read grant (we=0, id=b):
  - bank_empty[b]=0: during ISSUE, bank_rd_en[b]=1, ack=1, rvalid=1. rdata = bank_rdata slice b captured at the grant edge.
  - bank_empty[b]=1: during ISSUE, ack=1, err=1, no strobe, rdata unchanged.
- Write grant:
  - Target = first bank b, searching wptr, wptr+1, ... (mod NB), with bank_full[b]=0.
  - Target found: during ISSUE, bank_wr_en[b]=1, bank_wdata=wdata, ack=1; wptr=b+1 mod NB, wrapping NB-1 to 0.
  - All banks full: ack=1, err=1, no strobe, wptr unchanged.
- Exactly one of bank_wr_en/bank_rd_en has at most one bit set, and only in ISSUE; both are 0 in IDLE.
- The non-granted master's outputs stay 0 and its request remains pending.
- Masters must not drop req before ack. Behaviour is undefined if they do, but the arbiter never strobes a bank outside ISSUE.
- Reset mid-ISSUE: strobes and acks drop immediately; the operation is lost.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs stat_gnt0, stat_gnt1, stat_err (16-bit each).
  - stat_gnt0 and stat_gnt1 count grants per master; stat_err counts err acks.
  - All three saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 with random inputs → every output 0; after release with no req, all outputs stay 0.
- M0 writes 0xA5, 0x11, 0x22, 0x33, 0x44 with flags all 0 → bank_wr_en = 0001, 0010, 0100, 1000, 0001; bank_wdata matches each write; m0_ack 1 cycle after req sampled; spacing of 2 cycles.
- M0 and M1 both hold req continuously from reset release → grants alternate M0, M1, M0, M1, starting with M0; never two acks in one cycle.
- M1 reads id=2 with bank_empty=0100 → m1_ack=1, m1_err=1, m1_rvalid=0, bank_rd_en=0. Then bank_empty=0000 and bank_rdata slice 2 = 0x5C → m1_rdata=0x5C, m1_rvalid=1, bank_rd_en=0100.
- wptr=0, bank_full=1011, M0 write 0x7E → bank_wr_en=0100, next write targets bank 3 (if not full). bank_full=1111 → ack with err=1, no strobe.
- Assert rst=0 while bank_wr_en=0010 in ISSUE → strobe deasserts before the next clock edge; after release, state is IDLE and M0 gets the first grant.
